data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory port, for use once the core moves to a handshaked bus.
- Accepts one load/store request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, performs the word access with byte enables, and returns read data and an error flag over a valid/ready response channel.
- Used to exercise stall-capable datapaths against a memory with realistic latency.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; word index is req_addr[31:2].
- WAIT_CYCLES, 2, wait states between request acceptance and memory access; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; wait counter and the captured request are cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All memory words are cleared to 0.
  - Reset mid-operation (WAIT or RESP) aborts the transaction. A store that has not yet reached its access cycle is never committed. A pending response is dropped.
- FSM states and transitions:
  - IDLE: req_ready=1.
    - On req_valid&&req_ready, capture we, addr, wdata and be.
    - If WAIT_CYCLES>0: load counter with WAIT_CYCLES-1 and go to WAIT.
    - Otherwise: perform the access this edge and go to RESP.
  - WAIT: req_ready=0.
    - Counter decrements each cycle.
    - When counter==0: perform the access this edge and go to RESP.
  - RESP: req_ready=0, rsp_valid=1.
    - rsp_rdata and rsp_err are registered and held stable until the handshake.
    - On rsp_valid&&rsp_ready: go to IDLE; rsp_valid, rsp_rdata and rsp_err return to 0 the next cycle.
    - rsp_ready may be held low indefinitely; the response persists.
- Latency: request accepted at edge N, rsp_valid high in the cycle following edge N+WAIT_CYCLES. Accepting with rsp_ready=1 gives 1+WAIT_CYCLES+1 cycles of occupancy per transaction.
- Request and response cannot overlap: no new request is accepted while in WAIT or RESP. Back-to-back requests see req_ready rise the cycle after the response handshake.
- Access rules, evaluated at the access edge on the captured request:
  - Error if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
    - rsp_err=1, rsp_rdata=0, memory unchanged.
  - Store without error: only byte lanes with be=1 are written; rsp_rdata=0, rsp_err=0.
    - be=4'b0000 is a legal no-op store returning rsp_err=0.
  - Load without error: rsp_rdata = full 32-bit word, regardless of be.
- Request inputs are sampled only at acceptance. Changes on req_* while in WAIT/RESP have no effect.
- No combinational path from req_* or rsp_ready to any output. All outputs are driven from registers/state.

Test Plan:
- Reset then load: rst high for 2 cycles; load addr 0x00000010 -> rsp_valid first high in the cycle following edge N+2 (acceptance edge N), rsp_rdata=0x00000000, rsp_err=0; req_ready=0 from the cycle after acceptance until the cycle after the response handshake.
- Store/load with byte enables:
  - Store 0xDEADBEEF, be=4'hF to 0x40, then load 0x40 -> 0xDEADBEEF.
  - Store 0x00001100, be=4'b0010 to 0x40, then load 0x40 -> 0xDEAD11EF.
- Errors:
  - Load from 0x42 -> rsp_err=1, rsp_rdata=0.
  - Store to byte address 4*DEPTH_WORDS (0x1000) -> rsp_err=1; a subsequent load of word 0 is unchanged.
- Response backpressure: hold rsp_ready=0 for 5 cycles during a load of 0x40 -> rsp_valid stays 1, rsp_rdata stable at 0xDEAD11EF, req_ready stays 0; request inputs toggled meanwhile are ignored; release rsp_ready -> returns to IDLE the next cycle.
- Reset mid-operation: store 0x12345678 to 0x80 and assert rst in the first WAIT cycle -> outputs return to reset values; a load of 0x80 after reset returns 0.
- WAIT_CYCLES=0 build: a load accepted at edge N shows rsp_valid in the cycle after edge N; back-to-back requests with rsp_ready=1 complete one transaction every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request in, WAIT_CYCLES wait
// states, byte-enabled word access, registered valid/ready response out.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_wdata   store flag, byte address, store data
//   req_be                        store byte-lane enables
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            load data, misaligned/out-of-range flag

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LD =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        accept;
  logic        acc_fire;
  req_t        in_req;
  req_t        cap;
  req_t        acc;
  logic        acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0] rd_word;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  assign in_req = '{
    we:    req_we,
    addr:  req_addr,
    wdata: req_wdata,
    be:    req_be
  };

  // With no wait states the access happens on the
  // acceptance edge, so it must use the live request.
  assign acc = NO_WAIT ? in_req : cap;

  assign acc_err = (acc.addr[1:0] != 2'b00) ||
                   (acc.addr[31:2] >= DEPTH_L);
  assign acc_idx = acc.addr[AW+1:2];
  assign rd_word = mem[acc_idx];

  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_fire  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            acc_fire  = 1'b1;
            state_nxt = S_RESP;
          end else begin
            cnt_nxt   = WAIT_LD;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          acc_fire  = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap <= in_req;
      end
    end
  end

  // Response registers: loaded on the access edge,
  // cleared on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (acc_fire) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || acc.we) ? 32'h0 : rd_word;
    end else if (state == S_RESP && rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (acc_fire && acc.we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc.be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc.wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one WAIT_CYCLES=2
// instance and one WAIT_CYCLES=0 instance.

module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        req_valid0 = 1'b0;
  logic        req_ready0;
  logic        req_we0 = 1'b0;
  logic [31:0] req_addr0 = '0;
  logic [31:0] req_wdata0 = '0;
  logic [3:0]  req_be0 = '0;
  logic        rsp_valid0;
  logic        rsp_ready0 = 1'b1;
  logic [31:0] rsp_rdata0;
  logic        rsp_err0;

  exp_t qa[$];
  exp_t q0[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rdata", rsp_rdata, e.rdata);
        chk("a_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid0 && rsp_ready0) begin
      if (q0.size() == 0) begin
        chk("z_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("z_rdata", rsp_rdata0, e.rdata);
        chk("z_err", {31'd0, rsp_err0}, {31'd0, e.err});
      end
    end
  end

  // Issue one request on the WAIT_CYCLES=2 instance; returns
  // 1ns after the acceptance edge.
  task automatic send(input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [3:0] be,
                      input logic [31:0] exp_rd,
                      input logic exp_err);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) chk("a_req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    qa.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (qa.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("a_rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bit ok;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    // Latency: accept at N, response visible after N+2.
    send(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lat_n1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_n1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_n2_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("lat_n3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lat_n3_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("lat_n4_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_n4_ready", {31'd0, req_ready}, 32'd1);
    drain();

    send(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    drain();
    send(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    drain();
    send(1'b1, 32'h40, 32'h00001100, 4'b0010, 32'h0, 1'b0);
    drain();
    send(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD11EF, 1'b0);
    drain();
    send(1'b1, 32'h40, 32'h0, 4'b0000, 32'h0, 1'b0);
    drain();
    send(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD11EF, 1'b0);
    drain();

    send(1'b0, 32'h42, 32'h0, 4'h0, 32'h0, 1'b1);
    drain();
    send(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    drain();
    send(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    drain();

    // Backpressure with request-input noise.
    rsp_ready = 1'b0;
    send(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD11EF, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) chk("bp_valid_timeout", 32'd0, 32'd1);
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_valid = ~req_valid;
      req_we    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'h0;
      req_be    = 4'hF;
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEAD11EF);
      chk("bp_stable", rsp_rdata, held);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_rdata", rsp_rdata, 32'd0);
    send(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD11EF, 1'b0);
    drain();

    // Reset in the first WAIT cycle drops the store.
    send(1'b1, 32'h80, 32'h12345678, 4'hF, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("mrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    send(1'b0, 32'h80, 32'h0, 4'h0, 32'h0, 1'b0);
    drain();
    send(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
    drain();

    // Zero-wait instance.
    @(posedge clk);
    #1;
    req_valid0 = 1'b1;
    req_we0    = 1'b1;
    req_addr0  = 32'h8;
    req_wdata0 = 32'hCAFEF00D;
    req_be0    = 4'hF;
    q0.push_back('{rdata: 32'h0, err: 1'b0});
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("z_lat_valid", {31'd0, rsp_valid0}, 32'd1);
    chk("z_lat_ready", {31'd0, req_ready0}, 32'd0);
    @(negedge clk);
    chk("z_idle_ready", {31'd0, req_ready0}, 32'd1);
    chk("z_idle_valid", {31'd0, rsp_valid0}, 32'd0);

    @(posedge clk);
    #1;
    req_valid0 = 1'b1;
    req_we0    = 1'b0;
    req_addr0  = 32'h8;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("z_b2b_ready", {31'd0, req_ready0},
          (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("z_b2b_valid", {31'd0, rsp_valid0},
          (k % 2 == 1) ? 32'd1 : 32'd0);
      if (req_ready0) begin
        q0.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
      end
    end
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("z_queue_empty", q0.size(), 32'd0);
    chk("a_queue_empty", qa.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
